// File: rtl/matrix_pkg.sv
// Shared types, parameter defaults and helpers for the sequential matrix multiplier.
package matrix_pkg;

  localparam int unsigned MAX_DIM_DEF = 5;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, RUN, ERR, DONE} state_e;

  function automatic int unsigned dim_w(input int unsigned max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

  function automatic int unsigned bus_w(input int unsigned data_w, input int unsigned max_dim);
    return 2 * max_dim * max_dim * data_w;
  endfunction

  // Element index within one half of the flat bus (row-major, MAX_DIM stride)
  function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                           input int unsigned max_dim);
    return r * max_dim + c;
  endfunction

  function automatic bit dims_valid(input int unsigned am, input int unsigned an,
                                    input int unsigned bm, input int unsigned bn,
                                    input bit tr, input int unsigned max_dim);
    bit in_range;
    in_range = (am >= 1) && (am <= max_dim) && (an >= 1) && (an <= max_dim) &&
               (bm >= 1) && (bm <= max_dim) && (bn >= 1) && (bn <= max_dim);
    return in_range && (tr ? (an == bn) : (an == bm));
  endfunction

endpackage

// File: rtl/matrix_mac_sat.sv
// Shared multiply-accumulate datapath plus the result output function (truncate or saturate).
module matrix_mac_sat #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 19,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum_c,
  output logic [DATA_W-1:0] f_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;

  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    sum_c = acc + ACC_W'(prod);
    f_c   = sum_c[DATA_W-1:0];
    if ((SAT_MODE != 0) && (|sum_c[ACC_W-1:DATA_W])) begin
      f_c = {DATA_W{1'b1}};
    end
  end

endmodule

// File: rtl/matrix_mac_seq.sv
// Sequential C = A*B / A*B^T over a flat matrix bus, one MAC per cycle, start/busy/done handshake.
module matrix_mac_seq
  import matrix_pkg::*;
#(
  parameter  int unsigned MAX_DIM  = MAX_DIM_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned SAT_MODE = 0,
  localparam int unsigned DIM_W    = dim_w(MAX_DIM),
  localparam int unsigned ACC_W    = acc_w(DATA_W, MAX_DIM),
  localparam int unsigned BUS_W    = bus_w(DATA_W, MAX_DIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             transpose_b,
  input  logic [DIM_W-1:0] a_m,
  input  logic [DIM_W-1:0] a_n,
  input  logic [DIM_W-1:0] b_m,
  input  logic [DIM_W-1:0] b_n,
  input  logic [BUS_W-1:0] matrices_in,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             error,
  output logic [DIM_W-1:0] c_m,
  output logic [DIM_W-1:0] c_n,
  output logic [BUS_W-1:0] matrices_out
);

  localparam int unsigned HALF_W = BUS_W / 2;
  localparam int unsigned OFF_W  = $clog2(HALF_W);

  state_e            state_q, state_d;
  logic [HALF_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, kd_q, kd_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DIM_W-1:0]  cm_q, cm_d, cn_q, cn_d;
  logic              tr_q, tr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d, error_q, error_d;

  logic [OFF_W-1:0]  a_off, b_off, c_off;
  logic [DATA_W-1:0] a_el, b_el, f_c;
  logic [ACC_W-1:0]  sum_c;

  // Operand fetch: B is walked column-wise normally, row-wise when transposed
  always_comb begin
    a_off = OFF_W'(elem_off(32'(i_q), 32'(k_q), MAX_DIM) * DATA_W);
    b_off = tr_q ? OFF_W'(elem_off(32'(j_q), 32'(k_q), MAX_DIM) * DATA_W)
                 : OFF_W'(elem_off(32'(k_q), 32'(j_q), MAX_DIM) * DATA_W);
    c_off = OFF_W'(elem_off(32'(i_q), 32'(j_q), MAX_DIM) * DATA_W);
    a_el  = a_q[a_off +: DATA_W];
    b_el  = b_q[b_off +: DATA_W];
  end

  matrix_mac_sat #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SAT_MODE(SAT_MODE)
  ) u_mac (
    .acc  (acc_q),
    .a    (a_el),
    .b    (b_el),
    .sum_c(sum_c),
    .f_c  (f_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    m_d     = m_q;
    n_d     = n_q;
    kd_d    = kd_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    cm_d    = cm_q;
    cn_d    = cn_q;
    tr_d    = tr_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = matrices_in[HALF_W-1:0];
          b_d     = matrices_in[BUS_W-1:HALF_W];
          tr_d    = transpose_b;
          m_d     = a_m;
          n_d     = transpose_b ? b_m : b_n;
          kd_d    = a_n;
          c_d     = '0;
          valid_d = 1'b0;
          error_d = 1'b0;
          cm_d    = '0;
          cn_d    = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          if (dims_valid(32'(a_m), 32'(a_n), 32'(b_m), 32'(b_n), transpose_b, MAX_DIM)) begin
            state_d = RUN;
          end else begin
            state_d = ERR;
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (k_q + DIM_W'(1) == kd_q) begin
          c_d[c_off +: DATA_W] = f_c;
          acc_d = '0;
          k_d   = '0;
          if (j_q + DIM_W'(1) == n_q) begin
            j_d = '0;
            if (i_q + DIM_W'(1) == m_q) begin
              i_d     = '0;
              state_d = DONE;
              done_d  = 1'b1;
              valid_d = 1'b1;
              cm_d    = m_q;
              cn_d    = n_q;
            end else begin
              i_d = i_q + DIM_W'(1);
            end
          end else begin
            j_d = j_q + DIM_W'(1);
          end
        end else begin
          acc_d = sum_c;
          k_d   = k_q + DIM_W'(1);
        end
      end
      ERR, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      kd_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      cm_q    <= '0;
      cn_q    <= '0;
      tr_q    <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      m_q     <= m_d;
      n_q     <= n_d;
      kd_q    <= kd_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cm_q    <= cm_d;
      cn_q    <= cn_d;
      tr_q    <= tr_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign valid        = valid_q;
  assign error        = error_q;
  assign c_m          = cm_q;
  assign c_n          = cn_q;
  assign matrices_out = {HALF_W'(0), c_q};

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Directed scoreboard bench for matrix_mac_seq; truncating and saturating instances share stimulus.
module tb_matrix_mac_seq;

  localparam int unsigned MD     = 5;
  localparam int unsigned DW     = 8;
  localparam int unsigned DIM_W  = 3;
  localparam int unsigned BUS_W  = 2 * MD * MD * DW;
  localparam int unsigned HALF_W = BUS_W / 2;
  localparam int          LIMIT  = 400;

  typedef int unsigned mat_t [0:MD-1][0:MD-1];

  typedef struct {
    logic [HALF_W-1:0] c_tr;
    logic [HALF_W-1:0] c_sat;
    logic [DIM_W-1:0]  cm;
    logic [DIM_W-1:0]  cn;
    logic              err;
    int                lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             transpose_b = 1'b0;
  logic [DIM_W-1:0] a_m = '0, a_n = '0, b_m = '0, b_n = '0;
  logic [BUS_W-1:0] matrices_in = '0;

  logic             busy0, done0, valid0, error0, busy1, done1, valid1, error1;
  logic [DIM_W-1:0] cm0, cn0, cm1, cn1;
  logic [BUS_W-1:0] out0, out1;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  matrix_mac_seq #(.MAX_DIM(MD), .DATA_W(DW), .SAT_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .transpose_b(transpose_b),
    .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n), .matrices_in(matrices_in),
    .busy(busy0), .done(done0), .valid(valid0), .error(error0),
    .c_m(cm0), .c_n(cn0), .matrices_out(out0)
  );

  matrix_mac_seq #(.MAX_DIM(MD), .DATA_W(DW), .SAT_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .transpose_b(transpose_b),
    .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n), .matrices_in(matrices_in),
    .busy(busy1), .done(done1), .valid(valid1), .error(error1),
    .c_m(cm1), .c_n(cn1), .matrices_out(out1)
  );

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HALF_W-1:0] pack(input mat_t m);
    logic [HALF_W-1:0] v = '0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        v[(r * MD + c) * DW +: DW] = DW'(m[r][c]);
    return v;
  endfunction

  // Reference model: full-precision dot products, then truncate or saturate
  task automatic issue(input int am, input int an, input int bm, input int bn,
                       input bit tr, input mat_t ma, input mat_t mb);
    exp_t e;
    bit   ok;
    int   m_r, n_r, s;
    ok = am >= 1 && am <= MD && an >= 1 && an <= MD && bm >= 1 && bm <= MD &&
         bn >= 1 && bn <= MD && (tr ? an == bn : an == bm);
    e.c_tr  = '0;
    e.c_sat = '0;
    e.cm    = '0;
    e.cn    = '0;
    e.err   = !ok;
    e.lat   = 1;
    if (ok) begin
      m_r = am;
      n_r = tr ? bm : bn;
      for (int i = 0; i < m_r; i++)
        for (int j = 0; j < n_r; j++) begin
          s = 0;
          for (int k = 0; k < an; k++)
            s += int'(ma[i][k]) * int'(tr ? mb[j][k] : mb[k][j]);
          e.c_tr[(i * MD + j) * DW +: DW]  = DW'(s);
          e.c_sat[(i * MD + j) * DW +: DW] = (s > 255) ? DW'(255) : DW'(s);
        end
      e.cm  = DIM_W'(m_r);
      e.cn  = DIM_W'(n_r);
      e.lat = m_r * n_r * an + 1;
    end
    sb.push_back(e);
    @(negedge clk);
    a_m         = DIM_W'(am);
    a_n         = DIM_W'(an);
    b_m         = DIM_W'(bm);
    b_n         = DIM_W'(bn);
    transpose_b = tr;
    matrices_in = {pack(mb), pack(ma)};
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done (bounded), optionally poking start/matrices_in at one cycle, then score
  task automatic finish_op(input int disturb_at);
    exp_t e;
    int   cyc = 1;
    chk("busy_after_accept", 400'(busy0), 400'(1));
    while (done0 !== 1'b1 && cyc < LIMIT) begin
      if (cyc == disturb_at) begin
        start       = 1'b1;
        matrices_in = ~matrices_in;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 400'(1), 400'(0));
      return;
    end
    e = sb.pop_front();
    chk("done_latency", 400'(cyc), 400'(e.lat));
    chk("done_sat_inst", 400'(done1), 400'(1));
    chk("error", 400'(error0), 400'(e.err));
    chk("valid", 400'(valid0), 400'(!e.err));
    chk("c_m", 400'(cm0), 400'(e.cm));
    chk("c_n", 400'(cn0), 400'(e.cn));
    chk("matrices_out_trunc", out0, {HALF_W'(0), e.c_tr});
    chk("matrices_out_sat", out1, {HALF_W'(0), e.c_sat});
    @(posedge clk);
    #1;
    chk("done_pulse_ends", 400'(done0), 400'(0));
    chk("busy_idle", 400'(busy0), 400'(0));
    chk("valid_held", 400'(valid0), 400'(!e.err));
    chk("error_held", 400'(error0), 400'(e.err));
    chk("out_held", out0, {HALF_W'(0), e.c_tr});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 400'(busy0), 400'(0));
    chk({tag, "_done"}, 400'(done0), 400'(0));
    chk({tag, "_valid"}, 400'(valid0), 400'(0));
    chk({tag, "_error"}, 400'(error0), 400'(0));
    chk({tag, "_cm_cn"}, 400'({cm0, cn0}), 400'(0));
    chk({tag, "_out0"}, out0, '0);
    chk({tag, "_out1"}, out1, '0);
  endtask

  initial begin
    mat_t ma, mb, ones, zero;
    exp_t drop;
    logic [BUS_W-1:0] snap;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        ones[r][c] = 1;
        zero[r][c] = 0;
      end

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    ma = zero; mb = zero;
    ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3;
    ma[1][0] = 4; ma[1][1] = 5; ma[1][2] = 6;
    mb[0][0] = 7; mb[0][1] = 8; mb[1][0] = 9; mb[1][1] = 10; mb[2][0] = 11; mb[2][1] = 12;
    issue(2, 3, 3, 2, 1'b0, ma, mb);
    finish_op(-1);
    snap = out0;
    chk("c11_const_154", 400'(snap[(1 * MD + 1) * DW +: DW]), 400'(154));

    issue(2, 3, 2, 2, 1'b0, ma, mb);
    finish_op(-1);

    ma = zero; mb = zero;
    ma[0][0] = 200; mb[0][0] = 200;
    issue(1, 1, 1, 1, 1'b0, ma, mb);
    finish_op(-1);
    snap = out1;
    chk("sat_const_ff", 400'(snap[DW-1:0]), 400'(8'hFF));

    ma = zero; mb = zero;
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    issue(2, 2, 2, 2, 1'b1, ma, mb);
    finish_op(-1);

    issue(5, 5, 5, 5, 1'b0, ones, ones);
    finish_op(40);

    issue(5, 5, 5, 5, 1'b0, ones, ones);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("reset_mid_run");
    drop = sb.pop_front();
    @(negedge clk);
    reset = 1'b1;

    ma = zero; mb = zero;
    ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3;
    ma[1][0] = 4; ma[1][1] = 5; ma[1][2] = 6;
    mb[0][0] = 7; mb[0][1] = 8; mb[1][0] = 9; mb[1][1] = 10; mb[2][0] = 11; mb[2][1] = 12;
    issue(2, 3, 3, 2, 1'b0, ma, mb);
    finish_op(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
